xgemac_rx_read_ctrl: RTL and testbench

XGEMAC_RX_READ_CTRL -- requirements
Module: xgemac_rx_read_ctrl

---
 rtl/xgemac_pkg.sv | 31 +++
 rtl/xgemac_sync_fifo.sv | 48 ++++
 rtl/xgemac_rx_read_ctrl.sv | 133 +++++++++++++
 tb/tb_xgemac_rx_read_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgemac_pkg.sv
// Shared types and helpers for the XGEMAC receive path: FSM state encoding,
// receive word layout, statistics counter width and a saturating add.
package xgemac_pkg;

  localparam int CNT_W     = 16;
  localparam int RX_DATA_W = 64;
  localparam int RX_MOD_W  = 3;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_READ  = 2'd1,
    RX_DRAIN = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic [RX_DATA_W-1:0] data;
    logic [RX_MOD_W-1:0]  mod;
    logic                 sop;
    logic                 eop;
    logic                 err;
  } rx_word_t;

  // Adds a small increment and clamps at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/xgemac_sync_fifo.sv
// Single-clock skid FIFO with extra-MSB pointers; read data is combinational
// from the head entry and forced to zero while empty.
module xgemac_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_count = r_wr_ptr - r_rd_ptr;
  assign w_push  = i_wr_en && !o_full;
  assign w_pop   = i_rd_en && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/xgemac_rx_read_ctrl.sv
// Pulls frames out of the XGEMAC receive interface with credit-based read
// enables, buffers them in a skid FIFO and keeps frame/error statistics.
module xgemac_rx_read_ctrl
  import xgemac_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int MOD_W      = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              pkt_rx_ren,
  input  logic              pkt_rx_avail,
  input  logic              pkt_rx_val,
  input  logic              pkt_rx_sop,
  input  logic              pkt_rx_eop,
  input  logic              pkt_rx_err,
  input  logic [DATA_W-1:0] pkt_rx_data,
  input  logic [MOD_W-1:0]  pkt_rx_mod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [MOD_W-1:0]  out_mod,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_err,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_frame_cnt,
  output logic [CNT_W-1:0]  proto_err_cnt
);

  localparam int WORD_W = DATA_W + MOD_W + 3;
  localparam int AW     = $clog2(FIFO_DEPTH);

  rx_state_t         r_state;
  rx_state_t         w_state_nxt;
  logic              r_inflight;
  logic              r_in_frame;
  logic [CNT_W-1:0]  r_frame_cnt;
  logic [CNT_W-1:0]  r_err_frame_cnt;
  logic [CNT_W-1:0]  r_proto_err_cnt;
  logic [WORD_W-1:0] w_wr_word;
  logic [WORD_W-1:0] w_rd_word;
  logic              w_full;
  logic              w_empty;
  logic [AW:0]       w_count;
  logic [AW:0]       w_free;
  logic              w_credit_ok;
  logic              w_ren;
  logic              w_eop_seen;
  logic              w_seq_err;
  logic              w_ovf;
  logic [1:0]        w_proto_inc;

  assign w_free      = (AW+1)'(FIFO_DEPTH) - w_count;
  // A read issued last cycle lands this cycle, so its slot is already spoken for.
  assign w_credit_ok = w_free >= ((AW+1)'(2) + {{AW{1'b0}}, r_inflight});
  assign w_eop_seen  = pkt_rx_val && pkt_rx_eop;

  always_comb begin
    w_state_nxt = r_state;
    w_ren       = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (pkt_rx_avail && (w_free >= (AW+1)'(2))) w_state_nxt = RX_READ;
      end
      RX_READ: begin
        w_ren = w_credit_ok && !w_eop_seen;
        if (w_eop_seen) w_state_nxt = RX_DRAIN;
      end
      RX_DRAIN: w_state_nxt = RX_IDLE;
      default:  w_state_nxt = RX_IDLE;
    endcase
  end

  assign pkt_rx_ren = w_ren;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= RX_IDLE;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_ren;
    end
  end

  assign w_seq_err   = pkt_rx_val && (pkt_rx_sop ? r_in_frame : !r_in_frame);
  assign w_ovf       = pkt_rx_val && w_full;
  assign w_proto_inc = {1'b0, w_seq_err} + {1'b0, w_ovf};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_frame      <= 1'b0;
      r_frame_cnt     <= '0;
      r_err_frame_cnt <= '0;
      r_proto_err_cnt <= '0;
    end else begin
      if (pkt_rx_val) begin
        if (pkt_rx_eop)      r_in_frame <= 1'b0;
        else if (pkt_rx_sop) r_in_frame <= 1'b1;
      end
      r_frame_cnt     <= sat_add(r_frame_cnt, {1'b0, w_eop_seen});
      r_err_frame_cnt <= sat_add(r_err_frame_cnt, {1'b0, w_eop_seen && pkt_rx_err});
      r_proto_err_cnt <= sat_add(r_proto_err_cnt, w_proto_inc);
    end
  end

  assign frame_cnt     = r_frame_cnt;
  assign err_frame_cnt = r_err_frame_cnt;
  assign proto_err_cnt = r_proto_err_cnt;

  assign w_wr_word = {pkt_rx_data, pkt_rx_mod, pkt_rx_sop, pkt_rx_eop, pkt_rx_err};

  xgemac_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .i_wr_en   (pkt_rx_val),
    .i_wr_data (w_wr_word),
    .i_rd_en   (out_ready),
    .o_rd_data (w_rd_word),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign out_valid = !w_empty;
  assign {out_data, out_mod, out_sop, out_eop, out_err} = w_rd_word;

endmodule

// File: tb/tb_xgemac_rx_read_ctrl.sv
// Directed bench for xgemac_rx_read_ctrl with a 1-cycle-latency MAC model.
module tb_xgemac_rx_read_ctrl;

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  mod;
    logic        sop;
    logic        eop;
    logic        err;
  } w_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pkt_rx_ren;
  logic        avail = 1'b0, val = 1'b0, sop = 1'b0, eop = 1'b0, err = 1'b0;
  logic [63:0] data = '0;
  logic [2:0]  mod = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [2:0]  out_mod;
  logic        out_sop, out_eop, out_err;
  logic [15:0] frame_cnt, err_frame_cnt, proto_err_cnt;

  int   total = 0;
  int   bad   = 0;
  w_t   mac_q[$];
  w_t   exp_q[$];
  w_t   rx_q[$];
  logic ren_s = 1'b0;

  always #5 clk = ~clk;

  xgemac_rx_read_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_rx_ren    (pkt_rx_ren),
    .pkt_rx_avail  (avail),
    .pkt_rx_val    (val),
    .pkt_rx_sop    (sop),
    .pkt_rx_eop    (eop),
    .pkt_rx_err    (err),
    .pkt_rx_data   (data),
    .pkt_rx_mod    (mod),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_mod       (out_mod),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .out_err       (out_err),
    .frame_cnt     (frame_cnt),
    .err_frame_cnt (err_frame_cnt),
    .proto_err_cnt (proto_err_cnt)
  );

  // One clock: record a downstream pop, let the MAC answer last cycle's ren,
  // then sample ren on the falling edge.
  task automatic cycle();
    w_t w;
    if (out_valid && out_ready)
      rx_q.push_back({out_data, out_mod, out_sop, out_eop, out_err});
    @(posedge clk);
    #1;
    if (ren_s && mac_q.size() != 0) begin
      w = mac_q.pop_front();
      val = 1'b1; data = w.data; mod = w.mod; sop = w.sop; eop = w.eop; err = w.err;
    end else begin
      val = 1'b0; data = '0; mod = '0; sop = 1'b0; eop = 1'b0; err = 1'b0;
    end
    avail = (mac_q.size() != 0);
    @(negedge clk);
    ren_s = pkt_rx_ren;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    val = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0; data = '0; mod = '0;
    avail = 1'b0; ren_s = 1'b0;
    mac_q.delete(); exp_q.delete(); rx_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic push_frame(input int n, input logic [63:0] base,
                            input logic [2:0] lastmod, input logic lasterr);
    w_t w;
    for (int i = 0; i < n; i++) begin
      w.data = base + 64'(i);
      w.mod  = (i == n-1) ? lastmod : 3'd0;
      w.sop  = (i == 0);
      w.eop  = (i == n-1);
      w.err  = (i == n-1) ? lasterr : 1'b0;
      mac_q.push_back(w);
      exp_q.push_back(w);
    end
    avail = 1'b1;
  endtask

  task automatic run_until(input int n, input int budget, output bit ok);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      cycle();
      c++;
    end
    ok = (rx_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b0; avail = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (pkt_rx_ren !== 1'b0) begin bad++; $display("FAIL rst_ren: got %b want 0", pkt_rx_ren); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++; if ({out_data, out_mod, out_sop, out_eop, out_err} !== '0) begin bad++;
      $display("FAIL rst_outword: got %h/%h/%b%b%b want zero", out_data, out_mod, out_sop, out_eop, out_err); end
    total++; if ({frame_cnt, err_frame_cnt, proto_err_cnt} !== 48'd0) begin bad++;
      $display("FAIL rst_counters: got %h %h %h want 0", frame_cnt, err_frame_cnt, proto_err_cnt); end
    rst = 1'b1;
    #1;
    total++; if (pkt_rx_ren !== 1'b0) begin bad++; $display("FAIL rst_release_ren: got %b want 0", pkt_rx_ren); end
  endtask

  task automatic test_single_frame();
    bit ok, eop_seen;
    do_reset();
    out_ready = 1'b1;
    push_frame(3, 64'hA000_0000_0000_0000, 3'd3, 1'b0);
    eop_seen = 0;
    for (int c = 0; c < 40 && !(eop_seen && rx_q.size() >= 3); c++) begin
      cycle();
      if (val && eop && !eop_seen) begin
        eop_seen = 1;
        total++; if (ren_s !== 1'b0) begin bad++; $display("FAIL single_eop_ren: got %b want 0", ren_s); end
        cycle();
        total++; if (ren_s !== 1'b0) begin bad++; $display("FAIL single_drain_ren: got %b want 0", ren_s); end
      end
    end
    run_until(3, 20, ok);
    total++; if (rx_q.size() != 3) begin bad++; $display("FAIL single_count: got %0d want 3", rx_q.size()); end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL single_word%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    total++; if (rx_q.size() == 3 && rx_q[2].mod !== 3'd3) begin bad++; $display("FAIL single_mod: got %0d want 3", rx_q[2].mod); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL single_frame_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    out_ready = 1'b0;
    push_frame(10, 64'hB000_0000_0000_0100, 3'd0, 1'b0);
    repeat (20) cycle();
    total++; if (mac_q.size() != 7) begin bad++; $display("FAIL bp_reads_stalled: got %0d left want 7", mac_q.size()); end
    total++; if (pkt_rx_ren !== 1'b0) begin bad++; $display("FAIL bp_ren_low: got %b want 0", pkt_rx_ren); end
    repeat (3) cycle();
    total++; if (out_valid !== 1'b1 || out_data !== exp_q[0].data) begin bad++;
      $display("FAIL bp_hold: got v=%b %h want v=1 %h", out_valid, out_data, exp_q[0].data); end
    out_ready = 1'b1;
    run_until(10, 100, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_delivery: got %0d words want 10", rx_q.size()); end
    for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_word%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    total++; if (proto_err_cnt !== 16'd0) begin bad++; $display("FAIL bp_proto: got %0d want 0", proto_err_cnt); end
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL bp_frame_cnt: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_err_frame();
    bit ok;
    do_reset();
    out_ready = 1'b1;
    push_frame(2, 64'hC000_0000_0000_0200, 3'd5, 1'b1);
    run_until(2, 40, ok);
    total++; if (!ok || rx_q[1].err !== 1'b1 || rx_q[0].err !== 1'b0) begin bad++;
      $display("FAIL err_out_err: got %0d words want err=1 on last only", rx_q.size()); end
    repeat (2) cycle();
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL err_frame_cnt: got %0d want 1", frame_cnt); end
    total++; if (err_frame_cnt !== 16'd1) begin bad++; $display("FAIL err_err_cnt: got %0d want 1", err_frame_cnt); end
  endtask

  task automatic test_proto_err();
    bit ok;
    w_t t;
    do_reset();
    out_ready = 1'b1;
    push_frame(4, 64'hD000_0000_0000_0300, 3'd0, 1'b0);
    t = mac_q[2]; t.sop = 1'b1; mac_q[2] = t; exp_q[2] = t;
    run_until(4, 40, ok);
    total++; if (proto_err_cnt !== 16'd1) begin bad++; $display("FAIL proto_cnt: got %0d want 1", proto_err_cnt); end
    total++; if (rx_q.size() != 4) begin bad++; $display("FAIL proto_count: got %0d want 4", rx_q.size()); end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL proto_word%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok, in_gap, gap_done;
    int gap;
    do_reset();
    out_ready = 1'b1;
    push_frame(3, 64'hE000_0000_0000_0400, 3'd1, 1'b0);
    push_frame(3, 64'hE000_0000_0000_0500, 3'd2, 1'b0);
    gap = 0; in_gap = 0; gap_done = 0;
    for (int c = 0; c < 80 && rx_q.size() < 6; c++) begin
      cycle();
      if (!gap_done) begin
        if (!in_gap && val && eop) in_gap = 1;
        if (in_gap) begin
          if (ren_s) gap_done = 1;
          else gap++;
        end
      end
    end
    run_until(6, 10, ok);
    total++; if (gap != 3) begin bad++; $display("FAIL b2b_ren_gap: got %0d want 3", gap); end
    total++; if (!ok) begin bad++; $display("FAIL b2b_count: got %0d want 6", rx_q.size()); end
    for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_word%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    cycle();
    total++; if (frame_cnt !== 16'd2) begin bad++; $display("FAIL b2b_frame_cnt: got %0d want 2", frame_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int c;
    do_reset();
    out_ready = 1'b1;
    push_frame(1, 64'hF000_0000_0000_0600, 3'd4, 1'b0);
    run_until(1, 30, ok);
    cycle();
    total++; if (frame_cnt !== 16'd1) begin bad++; $display("FAIL rmf_pre_cnt: got %0d want 1", frame_cnt); end
    out_ready = 1'b0;
    push_frame(5, 64'hF000_0000_0000_0700, 3'd0, 1'b0);
    c = 0;
    while (mac_q.size() > 3 && c < 30) begin cycle(); c++; end
    total++; if (mac_q.size() != 3) begin bad++; $display("FAIL rmf_progress: got %0d left want 3", mac_q.size()); end
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmf_valid: got %b want 0", out_valid); end
    total++; if ({frame_cnt, err_frame_cnt, proto_err_cnt} !== 48'd0) begin bad++;
      $display("FAIL rmf_counters: got %h %h %h want 0", frame_cnt, err_frame_cnt, proto_err_cnt); end
    val = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0; avail = 1'b0; ren_s = 1'b0;
    mac_q.delete(); exp_q.delete(); rx_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    push_frame(2, 64'h1234_5678_9ABC_0800, 3'd6, 1'b0);
    run_until(2, 40, ok);
    repeat (5) cycle();
    total++; if (rx_q.size() != 2) begin bad++; $display("FAIL rmf_count: got %0d want 2", rx_q.size()); end
    for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
      total++; if (rx_q[i] !== exp_q[i]) begin bad++; $display("FAIL rmf_word%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
    total++; if (frame_cnt !== 16'd1 || proto_err_cnt !== 16'd0) begin bad++;
      $display("FAIL rmf_post_cnt: got %0d/%0d want 1/0", frame_cnt, proto_err_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_err_frame();
    test_proto_err();
    test_back_to_back();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
